// File: rtl/cpu_pkg.sv
// Shared types for the 2A03 control sequencer and datapath.
// States, select encodings, opcodes and the decoded-opcode bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    VEC_LO,
    VEC_HI,
    FETCH,
    DECODE,
    OPER_HI,
    MEM_RD,
    MEM_WR,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    ADDR_PC  = 2'd0,
    ADDR_ZP  = 2'd1,
    ADDR_ABS = 2'd2,
    ADDR_VEC = 2'd3
  } addr_sel_e;

  typedef enum logic [1:0] {
    PC_INC  = 2'd0,
    PC_JMP  = 2'd1,
    PC_HOLD = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    SRC_DIN  = 2'd0,
    SRC_XINC = 2'd1,
    SRC_A    = 2'd2
  } reg_src_e;

  typedef enum logic [1:0] {
    MODE_IMM,
    MODE_ZP,
    MODE_ABS,
    MODE_IMPL
  } mode_e;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_A,
    TGT_X,
    TGT_Y
  } tgt_e;

  typedef struct packed {
    mode_e    mode;
    tgt_e     tgt;
    reg_src_e src;
    logic     is_store;
    logic     is_jump;
    logic     legal;
  } dec_t;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_NOP     = 8'hEA;

endpackage

// File: rtl/cpu_opcode_decode.sv
// Opcode classifier: IR contents to addressing mode, target and flags.
// Anything outside the supported subset comes out with legal=0.
module cpu_opcode_decode
  import cpu_pkg::*;
(
  input  logic [7:0] IR_q,
  output dec_t       dec
);

  always_comb begin
    dec          = '0;
    dec.mode     = MODE_IMPL;
    dec.tgt      = TGT_NONE;
    dec.src      = SRC_DIN;
    dec.legal    = 1'b1;
    unique case (1'b1)
      (IR_q == OP_LDA_IMM): begin
        dec.mode = MODE_IMM;
        dec.tgt  = TGT_A;
      end
      (IR_q == OP_LDX_IMM): begin
        dec.mode = MODE_IMM;
        dec.tgt  = TGT_X;
      end
      (IR_q == OP_LDY_IMM): begin
        dec.mode = MODE_IMM;
        dec.tgt  = TGT_Y;
      end
      (IR_q == OP_LDA_ZP): begin
        dec.mode = MODE_ZP;
        dec.tgt  = TGT_A;
      end
      (IR_q == OP_STA_ZP): begin
        dec.mode     = MODE_ZP;
        dec.src      = SRC_A;
        dec.is_store = 1'b1;
      end
      (IR_q == OP_LDA_ABS): begin
        dec.mode = MODE_ABS;
        dec.tgt  = TGT_A;
      end
      (IR_q == OP_STA_ABS): begin
        dec.mode     = MODE_ABS;
        dec.src      = SRC_A;
        dec.is_store = 1'b1;
      end
      (IR_q == OP_JMP_ABS): begin
        dec.mode    = MODE_ABS;
        dec.is_jump = 1'b1;
      end
      (IR_q == OP_INX): begin
        dec.tgt = TGT_X;
        dec.src = SRC_XINC;
      end
      (IR_q == OP_TAX): begin
        dec.tgt = TGT_X;
        dec.src = SRC_A;
      end
      (IR_q == OP_NOP): ;
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control sequencer for the 2A03 datapath.
// Outputs are decoded from state, IR and mem_ready; state is registered.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] IR_q,
  input  logic       mem_ready,
  output logic       LD_A,
  output logic       LD_X,
  output logic       LD_Y,
  output logic       LD_P,
  output logic       LD_PC,
  output logic       LD_IR,
  output logic       LD_ADL,
  output logic       LD_ADH,
  output logic [1:0] addr_sel,
  output logic       vec_hi,
  output logic [1:0] pc_sel,
  output logic [1:0] reg_src,
  output logic       write,
  output logic       instr_done,
  output logic       halted
);

  state_e    state_q;
  state_e    state_d;
  state_e    mem_st;
  addr_sel_e data_sel;
  dec_t      dec;
  logic      rdy;

  cpu_opcode_decode u_dec (
    .IR_q (IR_q),
    .dec  (dec)
  );

  assign rdy      = mem_ready;
  assign mem_st   = dec.is_store ? MEM_WR : MEM_RD;
  assign data_sel = (dec.mode == MODE_ZP) ? ADDR_ZP : ADDR_ABS;

  always_ff @(posedge Clk) begin
    if (!reset) state_q <= VEC_LO;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      VEC_LO:  if (rdy) state_d = VEC_HI;
      VEC_HI:  if (rdy) state_d = FETCH;
      FETCH:   if (rdy) state_d = DECODE;
      DECODE: begin
        if (!dec.legal)                state_d = HALT;
        else if (dec.mode == MODE_IMPL) state_d = FETCH;
        else if (rdy) begin
          unique case (dec.mode)
            MODE_IMM: state_d = FETCH;
            MODE_ABS: state_d = OPER_HI;
            default:  state_d = mem_st;
          endcase
        end
      end
      OPER_HI: if (rdy) state_d = dec.is_jump ? FETCH : mem_st;
      MEM_RD:  if (rdy) state_d = FETCH;
      MEM_WR:  if (rdy) state_d = FETCH;
      HALT:    state_d = HALT;
    endcase
  end

  always_comb begin
    LD_A       = 1'b0;
    LD_X       = 1'b0;
    LD_Y       = 1'b0;
    LD_P       = 1'b0;
    LD_PC      = 1'b0;
    LD_IR      = 1'b0;
    LD_ADL     = 1'b0;
    LD_ADH     = 1'b0;
    addr_sel   = ADDR_PC;
    vec_hi     = 1'b0;
    pc_sel     = PC_HOLD;
    reg_src    = SRC_DIN;
    write      = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    // In reset everything is quiet and every select reads as zero
    if (!reset) begin
      pc_sel = PC_INC;
    end else begin
      unique case (state_q)
        VEC_LO: begin
          addr_sel = ADDR_VEC;
          LD_ADL   = rdy;
        end
        VEC_HI: begin
          addr_sel = ADDR_VEC;
          vec_hi   = 1'b1;
          pc_sel   = PC_JMP;
          LD_PC    = rdy;
        end
        FETCH: begin
          pc_sel = PC_INC;
          LD_IR  = rdy;
          LD_PC  = rdy;
        end
        DECODE: begin
          if (dec.legal) begin
            unique case (dec.mode)
              MODE_IMPL: begin
                reg_src    = dec.src;
                LD_X       = (dec.tgt == TGT_X);
                LD_P       = (dec.tgt != TGT_NONE);
                instr_done = 1'b1;
              end
              MODE_IMM: begin
                pc_sel     = PC_INC;
                LD_A       = rdy && (dec.tgt == TGT_A);
                LD_X       = rdy && (dec.tgt == TGT_X);
                LD_Y       = rdy && (dec.tgt == TGT_Y);
                LD_P       = rdy;
                LD_PC      = rdy;
                instr_done = rdy;
              end
              default: begin
                pc_sel = PC_INC;
                LD_ADL = rdy;
                LD_PC  = rdy;
              end
            endcase
          end
        end
        OPER_HI: begin
          if (dec.is_jump) begin
            pc_sel     = PC_JMP;
            LD_PC      = rdy;
            instr_done = rdy;
          end else begin
            pc_sel = PC_INC;
            LD_ADH = rdy;
            LD_PC  = rdy;
          end
        end
        MEM_RD: begin
          addr_sel   = data_sel;
          LD_A       = rdy;
          LD_P       = rdy;
          instr_done = rdy;
        end
        MEM_WR: begin
          addr_sel   = data_sel;
          reg_src    = SRC_A;
          write      = 1'b1;
          instr_done = rdy;
        end
        HALT: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: a behavioural datapath and memory around the
// sequencer, an instruction table, and hand sequences for halt/reset.
module tb_cpu_control;

  logic       Clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic       LD_A, LD_X, LD_Y, LD_P, LD_PC, LD_IR, LD_ADL, LD_ADH;
  logic [1:0] addr_sel, pc_sel, reg_src;
  logic       vec_hi, write, instr_done, halted;

  logic [7:0]  mem [0:65535];
  logic [7:0]  a = 8'h00, x = 8'h00, y = 8'h00, ir = 8'h00;
  logic [7:0]  adl = 8'h00, adh = 8'h00;
  logic [15:0] pc = 16'h0000;
  logic [15:0] addr;
  logic [7:0]  d_in, srcv;
  logic [9:0]  strb;
  int          acc_n = 0;
  logic [15:0] acc_addr = 16'h0;
  logic [7:0]  acc_data = 8'h0;
  int          excl_viol = 0;
  int          total = 0;
  int          bad = 0;

  always #5 Clk = ~Clk;

  cpu_control dut (
    .Clk        (Clk),
    .reset      (reset),
    .IR_q       (ir),
    .mem_ready  (mem_ready),
    .LD_A       (LD_A),
    .LD_X       (LD_X),
    .LD_Y       (LD_Y),
    .LD_P       (LD_P),
    .LD_PC      (LD_PC),
    .LD_IR      (LD_IR),
    .LD_ADL     (LD_ADL),
    .LD_ADH     (LD_ADH),
    .addr_sel   (addr_sel),
    .vec_hi     (vec_hi),
    .pc_sel     (pc_sel),
    .reg_src    (reg_src),
    .write      (write),
    .instr_done (instr_done),
    .halted     (halted)
  );

  assign strb = {LD_A, LD_X, LD_Y, LD_P, LD_PC, LD_IR,
                 LD_ADL, LD_ADH, write, instr_done};

  always_comb begin
    case (addr_sel)
      2'd0:    addr = pc;
      2'd1:    addr = {8'h00, adl};
      2'd2:    addr = {adh, adl};
      default: addr = 16'hFFFC + {15'd0, vec_hi};
    endcase
    d_in = mem[addr];
    case (reg_src)
      2'd0:    srcv = d_in;
      2'd1:    srcv = x + 8'd1;
      default: srcv = a;
    endcase
  end

  // Datapath model: register loads and accepted writes
  always @(posedge Clk) begin
    if (LD_ADL) adl <= d_in;
    if (LD_ADH) adh <= d_in;
    if (LD_IR)  ir  <= d_in;
    if (LD_PC)  pc  <= (pc_sel == 2'd0) ? pc + 16'd1 : {d_in, adl};
    if (LD_A)   a   <= srcv;
    if (LD_X)   x   <= srcv;
    if (LD_Y)   y   <= srcv;
    if (write && mem_ready) begin
      acc_n    <= acc_n + 1;
      acc_addr <= addr;
      acc_data <= a;
    end
  end

  always @(negedge Clk)
    if (write && (LD_PC || LD_IR)) excl_viol <= excl_viol + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  b0, b1, b2;
    int          len;
    int          cyc;
    logic [7:0]  ea, ex, ey;
    logic [15:0] epc;
    int          sa, sn;
    int          wc;
    logic [15:0] wa;
  } vec_t;

  vec_t tbl [11];
  vec_t exp_q [$];

  task automatic run(input vec_t v);
    int          c, sv, wn, wc;
    bit          done;
    logic [15:0] wa;
    vec_t        e;
    c = 0; sv = 0; wn = 0; wc = 0; wa = '0; done = 1'b0;
    exp_q.push_back(v);
    while (!done && c < 40) begin
      if (c > 0) @(negedge Clk);
      c++;
      mem_ready = !(c >= v.sa && c < v.sa + v.sn);
      #1;
      if (!mem_ready && (strb & 10'b11_1111_1101) != 0) sv++;
      if (write) begin
        wn++;
        if (wn == 1) begin
          wc = c;
          wa = addr;
        end
      end
      done = instr_done;
    end
    if (!done) chk({v.name, ":timeout"}, 0, 1);
    @(negedge Clk);
    mem_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    chk({e.name, ":cycles"}, c, e.cyc);
    chk({e.name, ":A"}, a, e.ea);
    chk({e.name, ":X"}, x, e.ex);
    chk({e.name, ":Y"}, y, e.ey);
    chk({e.name, ":PC"}, pc, e.epc);
    chk({e.name, ":stall_strobes"}, sv, 0);
    chk({e.name, ":write_cycles"}, wn, (e.wc != 0) ? 1 : 0);
    if (e.wc != 0) begin
      chk({e.name, ":write_at"}, wc, e.wc);
      chk({e.name, ":write_addr"}, wa, e.wa);
      chk({e.name, ":acc_addr"}, acc_addr, e.wa);
      chk({e.name, ":acc_data"}, acc_data, e.ea);
    end
  endtask

  initial begin
    int          acc0;
    logic [15:0] la;

    tbl[0]  = '{"LDA_imm",  8'hA9, 8'h42, 8'h00, 2, 2,
                8'h42, 8'h00, 8'h00, 16'h8002, 0, 0, 0, 16'h0};
    tbl[1]  = '{"LDX_imm_stall", 8'hA2, 8'h10, 8'h00, 2, 3,
                8'h42, 8'h10, 8'h00, 16'h8004, 2, 1, 0, 16'h0};
    tbl[2]  = '{"LDY_imm",  8'hA0, 8'hFF, 8'h00, 2, 2,
                8'h42, 8'h10, 8'hFF, 16'h8006, 0, 0, 0, 16'h0};
    tbl[3]  = '{"INX",      8'hE8, 8'h00, 8'h00, 1, 2,
                8'h42, 8'h11, 8'hFF, 16'h8007, 0, 0, 0, 16'h0};
    tbl[4]  = '{"LDA_zp",   8'hA5, 8'h10, 8'h00, 2, 3,
                8'h5A, 8'h11, 8'hFF, 16'h8009, 0, 0, 0, 16'h0};
    tbl[5]  = '{"TAX",      8'hAA, 8'h00, 8'h00, 1, 2,
                8'h5A, 8'h5A, 8'hFF, 16'h800A, 0, 0, 0, 16'h0};
    tbl[6]  = '{"NOP",      8'hEA, 8'h00, 8'h00, 1, 2,
                8'h5A, 8'h5A, 8'hFF, 16'h800B, 0, 0, 0, 16'h0};
    tbl[7]  = '{"STA_abs",  8'h8D, 8'h34, 8'h12, 3, 4,
                8'h5A, 8'h5A, 8'hFF, 16'h800E, 0, 0, 4, 16'h1234};
    tbl[8]  = '{"LDA_abs_stall", 8'hAD, 8'h00, 8'h20, 3, 6,
                8'hC3, 8'h5A, 8'hFF, 16'h8011, 3, 2, 0, 16'h0};
    tbl[9]  = '{"STA_zp",   8'h85, 8'h20, 8'h00, 2, 3,
                8'hC3, 8'h5A, 8'hFF, 16'h8013, 0, 0, 3, 16'h0020};
    tbl[10] = '{"JMP",      8'h4C, 8'h00, 8'h90, 3, 3,
                8'hC3, 8'h5A, 8'hFF, 16'h9000, 0, 0, 0, 16'h0};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h0010] = 8'h5A;
    mem[16'h2000] = 8'hC3;
    mem[16'h9000] = 8'h02;
    la = 16'h8000;
    for (int i = 0; i < 11; i++) begin
      mem[la] = tbl[i].b0;
      if (tbl[i].len > 1) mem[la + 16'd1] = tbl[i].b1;
      if (tbl[i].len > 2) mem[la + 16'd2] = tbl[i].b2;
      la = la + 16'(tbl[i].len);
    end

    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1;
      chk("rst:strobes", strb, 10'd0);
      chk("rst:halted", halted, 0);
      chk("rst:selects", {addr_sel, pc_sel, reg_src, vec_hi}, 0);
    end
    reset = 1'b1;
    #1;
    chk("vec_lo:addr", {addr_sel, vec_hi}, 3'b110);
    chk("vec_lo:ld_adl", LD_ADL, 1);
    @(negedge Clk);
    #1;
    chk("vec_hi:addr", {addr_sel, vec_hi, pc_sel}, 5'b111_01);
    chk("vec_hi:ld_pc", LD_PC, 1);
    @(negedge Clk);
    #1;
    chk("fetch0:pc", pc, 16'h8000);
    chk("fetch0:addr_sel", addr_sel, 0);
    chk("fetch0:ld_ir", {LD_IR, LD_PC}, 2'b11);

    for (int i = 0; i < 11; i++) run(tbl[i]);

    // Illegal opcode at the jump target: halt after decode
    chk("ill:fetch", {LD_IR, addr_sel}, 3'b100);
    chk("ill:pc", pc, 16'h9000);
    @(negedge Clk);
    #1;
    chk("ill:decode_quiet", {strb, halted}, 11'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("ill:halted", {strb, halted}, 11'd1);
    end

    // Reset taken while STA zp is stalled in its write cycle
    mem[16'hFFFD] = 8'hA0;
    mem[16'hA000] = 8'h85;
    mem[16'hA001] = 8'h30;
    mem_ready = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    #1;
    chk("rst2:vec_lo", {addr_sel, halted}, 3'b110);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("rst2:fetch_pc", pc, 16'hA000);
    @(negedge Clk);
    @(negedge Clk);
    mem_ready = 1'b0;
    #1;
    chk("rst2:mem_wr", {write, addr_sel}, 3'b101);
    acc0 = acc_n;
    @(negedge Clk);
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst2:write_drop", write, 0);
    @(negedge Clk);
    reset = 1'b1;
    #1;
    chk("rst2:restart", {addr_sel, vec_hi, LD_ADL}, 4'b1101);
    chk("rst2:no_write", acc_n, acc0);
    chk("excl:write_vs_pc_ir", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
